cargador_serie_operandos: RTL

Bit-serial operand loader that sits directly upstream of the right-to-left iterative comparator network. It accepts operands A and B one bit pair per clock, assembles them into K-bit words, and presents them in parallel to the comparator's `A`/`B` inputs. A valid/ready handshake holds each word stable until the consumer takes it. Bit order is LSB first by default, which matches the comparator's cell-0-is-LSB ordering.

---
 rtl/cargador_serie_operandos.sv | 113 +++++++++++
 1 files changed

// File: rtl/cargador_serie_operandos.sv
// Bit-serial operand loader: assembles K-bit A/B words from bit pairs and holds them for the
// comparator under a valid/ready handshake. Define CARGADOR_MSB_FIRST_EN for MSB-first arrival.
module cargador_serie_operandos #(
  parameter int unsigned K = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         in_valid_i,
  input  logic         a_bit_i,
  input  logic         b_bit_i,
  output logic         in_ready_o,
  output logic [K-1:0] a_out_o,
  output logic [K-1:0] b_out_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o
);

  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [K-1:0]    sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [K-1:0]    a_out_q, a_out_d, b_out_q, b_out_d;
  logic            out_valid_q, out_valid_d;
  logic [K-1:0]    sh_a_next, sh_b_next;

`ifdef CARGADOR_MSB_FIRST_EN
  assign sh_a_next = {sh_a_q[K-2:0], a_bit_i};
  assign sh_b_next = {sh_b_q[K-2:0], b_bit_i};
`else
  assign sh_a_next = {a_bit_i, sh_a_q[K-1:1]};
  assign sh_b_next = {b_bit_i, sh_b_q[K-1:1]};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StShift;
          cnt_d   = '0;
          sh_a_d  = '0;
          sh_b_d  = '0;
        end
      end
      StShift: begin
        // Abort outranks a same-cycle accept, even on the final bit.
        if (abort_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (in_valid_i) begin
          sh_a_d = sh_a_next;
          sh_b_d = sh_b_next;
          if (cnt_q == CntLast) begin
            a_out_d     = sh_a_next;
            b_out_d     = sh_b_next;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = StHold;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == StShift);
  assign busy_o      = (state_q != StIdle);
  assign a_out_o     = a_out_q;
  assign b_out_o     = b_out_q;
  assign out_valid_o = out_valid_q;

endmodule
